// File: rtl/pair_invariant_monitor_if.sv
// pair_invariant_monitor_if
// Groups the monitored handshake pair, the control inputs and the status outputs
// of pair_invariant_monitor into one bundle.
//   master : drives en, clr, a, b; observes status (the pair driver / debug side)
//   slave  : the monitor itself
// Signals:
//   en, clr        monitoring enable and synchronous clear
//   a, b           monitored pair
//   state          FSM state (00 IDLE, 01 RUN, 10 LOCK)
//   sample_cnt     samples checked, saturating
//   viol_cnt       violating samples, saturating
//   first_fail_idx sample index of the first violation
//   err_sticky     a violation has been seen since the last rst/clr
//   viol_pulse     one-cycle pulse following each violating sample
//   fail_lock      monitor has locked after too many consecutive violations
interface pair_invariant_monitor_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             en;
    logic             clr;
    logic             a;
    logic             b;
    logic [1:0]       state;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] viol_cnt;
    logic [CNT_W-1:0] first_fail_idx;
    logic             err_sticky;
    logic             viol_pulse;
    logic             fail_lock;

    modport master (
        output en, clr, a, b,
        input  state, sample_cnt, viol_cnt, first_fail_idx, err_sticky, viol_pulse, fail_lock
    );

    modport slave (
        input  en, clr, a, b,
        output state, sample_cnt, viol_cnt, first_fail_idx, err_sticky, viol_pulse, fail_lock
    );
endinterface

// File: rtl/pair_invariant_monitor.sv
// pair_invariant_monitor
// Run-time checker for the handshake pair (a, b): every sample taken in RUN must
// have exactly one of a, b high. Counts samples and violations, records the index
// of the first violation and locks after MAX_CONSEC consecutive violations.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset (highest priority)
//   mon  pair_invariant_monitor_if.slave: en, clr, a, b in; status out
module pair_invariant_monitor #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CONSEC = 3
) (
    input logic                   clk,
    input logic                   rst,
    pair_invariant_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StLock = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] ConsecMax = CNT_W'(MAX_CONSEC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
    logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic             err_sticky_q, err_sticky_d;
    logic             viol_pulse_q, viol_pulse_d;
    logic             violation;

    // Both low or both high breaks the one-hot invariant.
    assign violation = (mon.a == mon.b);

    always_comb begin
        state_d          = state_q;
        sample_cnt_d     = sample_cnt_q;
        viol_cnt_d       = viol_cnt_q;
        first_fail_idx_d = first_fail_idx_q;
        consec_d         = consec_q;
        err_sticky_d     = err_sticky_q;
        viol_pulse_d     = 1'b0;

        if (mon.clr) begin
            // Same end state as rst; this cycle's sample is discarded.
            state_d          = StIdle;
            sample_cnt_d     = '0;
            viol_cnt_d       = '0;
            first_fail_idx_d = '0;
            consec_d         = '0;
            err_sticky_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mon.en) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!mon.en) begin
                        state_d = StIdle;
                    end else begin
                        if (sample_cnt_q != CntMax) begin
                            sample_cnt_d = sample_cnt_q + 1'b1;
                        end
                        if (violation) begin
                            viol_pulse_d = 1'b1;
                            if (viol_cnt_q != CntMax) begin
                                viol_cnt_d = viol_cnt_q + 1'b1;
                            end
                            if (!err_sticky_q) begin
                                first_fail_idx_d = sample_cnt_q;
                                err_sticky_d     = 1'b1;
                            end
                            consec_d = (consec_q >= ConsecMax) ? ConsecMax : consec_q + 1'b1;
                            if (consec_d == ConsecMax) begin
                                state_d = StLock;
                            end
                        end else begin
                            consec_d = '0;
                        end
                    end
                end
                StLock: begin
                    // Frozen until rst or clr.
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            sample_cnt_q     <= '0;
            viol_cnt_q       <= '0;
            first_fail_idx_q <= '0;
            consec_q         <= '0;
            err_sticky_q     <= 1'b0;
            viol_pulse_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            sample_cnt_q     <= sample_cnt_d;
            viol_cnt_q       <= viol_cnt_d;
            first_fail_idx_q <= first_fail_idx_d;
            consec_q         <= consec_d;
            err_sticky_q     <= err_sticky_d;
            viol_pulse_q     <= viol_pulse_d;
        end
    end

    assign mon.state          = state_q;
    assign mon.sample_cnt     = sample_cnt_q;
    assign mon.viol_cnt       = viol_cnt_q;
    assign mon.first_fail_idx = first_fail_idx_q;
    assign mon.err_sticky     = err_sticky_q;
    assign mon.viol_pulse     = viol_pulse_q;
    assign mon.fail_lock      = (state_q == StLock);

endmodule

// File: tb/tb_pair_invariant_monitor.sv
// Bench for pair_invariant_monitor: two instances (CNT_W=16 and CNT_W=4) share the
// same stimulus. A behavioural model per instance is compared every cycle, plus
// literal expectations for the directed scenarios.
module tb_pair_invariant_monitor;

    logic clk;
    logic rst;
    logic en;
    logic clr;
    logic a;
    logic b;

    int errors = 0;
    int checks = 0;
    bit model_valid = 0;
    bit done = 0;

    pair_invariant_monitor_if #(.CNT_W(16)) m16 ();
    pair_invariant_monitor_if #(.CNT_W(4))  m4 ();

    assign m16.en  = en;
    assign m16.clr = clr;
    assign m16.a   = a;
    assign m16.b   = b;
    assign m4.en   = en;
    assign m4.clr  = clr;
    assign m4.a    = a;
    assign m4.b    = b;

    pair_invariant_monitor #(.CNT_W(16), .MAX_CONSEC(3)) dut16 (
        .clk (clk),
        .rst (rst),
        .mon (m16)
    );

    pair_invariant_monitor #(.CNT_W(4), .MAX_CONSEC(3)) dut4 (
        .clk (clk),
        .rst (rst),
        .mon (m4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: mode 0 idle, 1 run, 2 lock.
    int mode   [2];
    int scnt   [2];
    int vcnt   [2];
    int ffi    [2];
    int err    [2];
    int pulse  [2];
    int consec [2];
    int maxv   [2] = '{65535, 15};
    localparam int MaxConsec = 3;

    task automatic model_step(input int d);
        if (rst || clr) begin
            mode[d] = 0; scnt[d] = 0; vcnt[d] = 0; ffi[d] = 0;
            err[d] = 0; pulse[d] = 0; consec[d] = 0;
        end else begin
            pulse[d] = 0;
            if (mode[d] == 0) begin
                if (en) mode[d] = 1;
            end else if (mode[d] == 1) begin
                if (!en) begin
                    mode[d] = 0;
                end else begin
                    if (a == b) begin
                        if (err[d] == 0) begin
                            ffi[d] = scnt[d];
                            err[d] = 1;
                        end
                        if (vcnt[d] < maxv[d]) vcnt[d]++;
                        if (consec[d] < MaxConsec) consec[d]++;
                        pulse[d] = 1;
                        if (consec[d] == MaxConsec) mode[d] = 2;
                    end else begin
                        consec[d] = 0;
                    end
                    if (scnt[d] < maxv[d]) scnt[d]++;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
        if (rst) model_valid = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input logic [1:0] st, input logic [15:0] sc,
                           input logic [15:0] vc, input logic [15:0] ff, input logic e,
                           input logic p, input logic fl);
        string tag;
        tag = (d == 0) ? "w16" : "w4";
        chk({tag, ".state"}, 32'(st), mode[d]);
        chk({tag, ".sample_cnt"}, 32'(sc), scnt[d]);
        chk({tag, ".viol_cnt"}, 32'(vc), vcnt[d]);
        chk({tag, ".first_fail_idx"}, 32'(ff), ffi[d]);
        chk({tag, ".err_sticky"}, 32'(e), err[d]);
        chk({tag, ".viol_pulse"}, 32'(p), pulse[d]);
        chk({tag, ".fail_lock"}, 32'(fl), (mode[d] == 2) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        if (model_valid && !done) begin
            cmp_dut(0, m16.state, m16.sample_cnt, m16.viol_cnt, m16.first_fail_idx,
                    m16.err_sticky, m16.viol_pulse, m16.fail_lock);
            cmp_dut(1, m4.state, 16'(m4.sample_cnt), 16'(m4.viol_cnt),
                    16'(m4.first_fail_idx), m4.err_sticky, m4.viol_pulse, m4.fail_lock);
        end
    end

    task automatic drive(input logic r, input logic e, input logic c, input logic av,
                         input logic bv);
        rst = r; en = e; clr = c; a = av; b = bv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;

        // Reset then idle with an illegal pair present.
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, 1);
            chk("idle.viol_pulse", 32'(m16.viol_pulse), 0);
        end
        chk("idle.state", 32'(m16.state), 0);
        chk("idle.sample_cnt", 32'(m16.sample_cnt), 0);
        chk("idle.viol_cnt", 32'(m16.viol_cnt), 0);
        chk("idle.err_sticky", 32'(m16.err_sticky), 0);

        // Clean run: 20 alternating legal samples.
        drive(0, 1, 0, 1, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, 0, (i % 2) == 0, (i % 2) != 0);
        chk("clean.sample_cnt", 32'(m16.sample_cnt), 20);
        chk("clean.viol_cnt", 32'(m16.viol_cnt), 0);
        chk("clean.err_sticky", 32'(m16.err_sticky), 0);
        chk("clean.state", 32'(m16.state), 1);
        chk("sat.sample_cnt_w4", 32'(m4.sample_cnt), 15);

        // clr mid-run with a==b clears everything.
        drive(0, 1, 1, 1, 1);
        chk("clr.state", 32'(m16.state), 0);
        chk("clr.sample_cnt", 32'(m16.sample_cnt), 0);
        chk("clr.sample_cnt_w4", 32'(m4.sample_cnt), 0);
        chk("clr.viol_cnt", 32'(m16.viol_cnt), 0);
        chk("clr.err_sticky", 32'(m16.err_sticky), 0);

        // Isolated violations at samples 5 and 9.
        drive(0, 1, 0, 1, 0);
        for (int k = 0; k < 12; k++) begin
            logic v;
            v = (k == 5) || (k == 9);
            drive(0, 1, 0, 1, v);
            chk($sformatf("iso.viol_pulse[%0d]", k), 32'(m16.viol_pulse), 32'(v));
        end
        chk("iso.viol_cnt", 32'(m16.viol_cnt), 2);
        chk("iso.first_fail_idx", 32'(m16.first_fail_idx), 5);
        chk("iso.err_sticky", 32'(m16.err_sticky), 1);
        chk("iso.state", 32'(m16.state), 1);

        // Lock after three consecutive violations starting at sample 2.
        drive(0, 1, 1, 1, 1);
        drive(0, 1, 0, 1, 0);
        drive(0, 1, 0, 1, 0);
        drive(0, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 1);
        chk("lock.fail_lock_early", 32'(m16.fail_lock), 0);
        drive(0, 1, 0, 0, 0);
        chk("lock.fail_lock", 32'(m16.fail_lock), 1);
        chk("lock.state", 32'(m16.state), 2);
        chk("lock.viol_cnt", 32'(m16.viol_cnt), 3);
        chk("lock.first_fail_idx", 32'(m16.first_fail_idx), 2);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
        chk("lock.sample_cnt", 32'(m16.sample_cnt), 5);
        chk("lock.viol_cnt_frozen", 32'(m16.viol_cnt), 3);
        chk("lock.viol_pulse", 32'(m16.viol_pulse), 0);

        // Consecutive count broken by a legal sample, plus an en pause.
        drive(0, 1, 1, 1, 1);
        chk("unlock.state", 32'(m16.state), 0);
        drive(0, 1, 0, 1, 0);
        drive(0, 1, 0, 1, 1);
        drive(0, 1, 0, 1, 1);
        drive(0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1);
        chk("pause.sample_cnt", 32'(m16.sample_cnt), 3);
        chk("pause.viol_cnt", 32'(m16.viol_cnt), 2);
        chk("pause.state", 32'(m16.state), 0);
        drive(0, 1, 0, 1, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        chk("consec.viol_cnt", 32'(m16.viol_cnt), 4);
        chk("consec.sample_cnt", 32'(m16.sample_cnt), 5);
        chk("consec.state", 32'(m16.state), 1);
        chk("consec.fail_lock", 32'(m16.fail_lock), 0);

        // Randomized traffic; the per-cycle model comparison does the checking.
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic av;
            r  = $urandom_range(0, 199);
            av = 1'($urandom);
            drive(r == 0, $urandom_range(0, 9) != 0, r < 4 && r != 0, av,
                  ($urandom_range(0, 9) < 3) ? av : ~av);
        end

        done = 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
